// File: rtl/chip7458_sequencer_pkg.sv
// Shared types and constants for the 7458 exerciser and its golden model.
package chip74_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } seq_state_t;

    localparam int              VEC_W    = 10;
    localparam logic [VEC_W-1:0] VEC_LAST = 10'h3FF;

    // Bit positions of the chip pins inside the driven vector.
    localparam int P1A_BIT = 0;
    localparam int P1B_BIT = 1;
    localparam int P1C_BIT = 2;
    localparam int P1D_BIT = 3;
    localparam int P1E_BIT = 4;
    localparam int P1F_BIT = 5;
    localparam int P2A_BIT = 6;
    localparam int P2B_BIT = 7;
    localparam int P2C_BIT = 8;
    localparam int P2D_BIT = 9;

endpackage

// File: rtl/chip7458_sequencer_if.sv
// Harness-side control/status bundle of the 7458 exerciser.
interface chip7458_sequencer_if #(
    parameter int ERR_W = 11
);
    import chip74_pkg::*;

    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic             first_fail_valid;
    logic [VEC_W-1:0] first_fail_vec;

    // Harness side: issues start/abort, observes status.
    modport master (
        output start, abort,
        input  busy, done, pass, err_count, first_fail_valid, first_fail_vec
    );

    // Sequencer side.
    modport slave (
        input  start, abort,
        output busy, done, pass, err_count, first_fail_valid, first_fail_vec
    );

endinterface

// File: rtl/chip7458_sequencer_golden.sv
// Reference behaviour of the dual AND-OR chip; purely combinational.
module chip7458_golden
    import chip74_pkg::*;
(
    input  logic [VEC_W-1:0] vec_i,
    output logic             exp1_o,
    output logic             exp2_o
);

    // Section 1: two 3-input ANDs into an OR; section 2: two 2-input ANDs into an OR.
    assign exp1_o = (vec_i[P1A_BIT] & vec_i[P1B_BIT] & vec_i[P1C_BIT])
                  | (vec_i[P1D_BIT] & vec_i[P1E_BIT] & vec_i[P1F_BIT]);
    assign exp2_o = (vec_i[P2A_BIT] & vec_i[P2B_BIT])
                  | (vec_i[P2C_BIT] & vec_i[P2D_BIT]);

endmodule

// File: rtl/chip7458_sequencer.sv
// Exhaustive exerciser: drives all 1024 input vectors into a 7458, waits for
// settling, compares against the golden model and tallies mismatches.
module chip7458_sequencer
    import chip74_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    chip7458_sequencer_if.slave  ctl,
    output logic [VEC_W-1:0]     dut_in_o,
    input  logic                 dut_p1y_i,
    input  logic                 dut_p2y_i
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    seq_state_t       state_q;
    logic [VEC_W-1:0] vec_q;
    logic [VEC_W-1:0] dut_in_q;
    logic [CNT_W-1:0] settle_q;
    logic [ERR_W-1:0] err_count_q;
    logic [ERR_W-1:0] err_count_d;
    logic             ffv_q;
    logic [VEC_W-1:0] ffvec_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    logic exp1, exp2, mismatch, in_run;

    chip7458_golden u_golden (
        .vec_i  (vec_q),
        .exp1_o (exp1),
        .exp2_o (exp2)
    );

    // Compare chip outputs with the model; saturating error increment.
    always_comb begin
        mismatch    = (dut_p1y_i != exp1) | (dut_p2y_i != exp2);
        err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + 1'b1;
        in_run      = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == SAMPLE);
    end

    // Sequencer FSM with all status outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            dut_in_q    <= '0;
            settle_q    <= '0;
            err_count_q <= '0;
            ffv_q       <= 1'b0;
            ffvec_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else if (ctl.abort && in_run) begin
            // Results and pins are left as they were for post-mortem.
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // abort outranks start even when idle.
                    if (ctl.start && !ctl.abort) begin
                        state_q     <= DRIVE;
                        vec_q       <= '0;
                        err_count_q <= '0;
                        ffv_q       <= 1'b0;
                        ffvec_q     <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                    end
                end
                DRIVE: begin
                    dut_in_q <= vec_q;
                    settle_q <= '0;
                    state_q  <= SETTLE;
                end
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_q <= SAMPLE;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_count_q <= err_count_d;
                        if (!ffv_q) begin
                            ffv_q   <= 1'b1;
                            ffvec_q <= vec_q;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        // Final vector's result is folded into pass here.
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_count_q == '0) && !mismatch;
                    end else begin
                        vec_q   <= vec_q + 1'b1;
                        state_q <= DRIVE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dut_in_o             = dut_in_q;
    assign ctl.busy             = busy_q;
    assign ctl.done             = done_q;
    assign ctl.pass             = pass_q;
    assign ctl.err_count        = err_count_q;
    assign ctl.first_fail_valid = ffv_q;
    assign ctl.first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_chip7458_sequencer.sv
// Directed bench for chip7458_sequencer with a behavioural 7458 that can be
// forced into stuck-output faults.
module tb_chip7458_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] dut_in;
    logic       p1y, p2y;
    int         mode;   // 0 good chip, 1 p1y stuck 0, 2 p2y stuck 1
    int         n_chk = 0;
    int         n_err = 0;
    int         n;

    chip7458_sequencer_if #(.ERR_W(11)) ctl ();

    chip7458_sequencer #(.SETTLE_CYCLES(2), .ERR_W(11)) dut (
        .clk       (clk),
        .reset     (reset),
        .ctl       (ctl),
        .dut_in_o  (dut_in),
        .dut_p1y_i (p1y),
        .dut_p2y_i (p2y)
    );

    always #5 clk = ~clk;

    // Chip model written from the datasheet equations, with fault injection.
    always_comb begin
        p1y = (dut_in[0] && dut_in[1] && dut_in[2]) || (dut_in[3] && dut_in[4] && dut_in[5]);
        p2y = (dut_in[6] && dut_in[7]) || (dut_in[8] && dut_in[9]);
        if (mode == 1) p1y = 1'b0;
        if (mode == 2) p2y = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; returns 1 time unit after the accepting edge.
    task automatic start_run();
        ctl.start = 1'b1;
        tick();
        ctl.start = 1'b0;
    endtask

    // Count edges until done rises, bounded; also flags any premature busy drop.
    task automatic wait_done(input string tag, output int cyc);
        int gaps;
        cyc  = 0;
        gaps = 0;
        while (cyc < 6000) begin
            tick();
            cyc++;
            if (ctl.done) break;
            if (!ctl.busy) gaps++;
        end
        chk({tag, "_busy_gap"}, gaps, 0);
    endtask

    initial begin
        mode      = 0;
        reset     = 1'b1;
        ctl.start = 1'b0;
        ctl.abort = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        chk("rst_busy", ctl.busy, 0);
        chk("rst_done", ctl.done, 0);
        chk("rst_pass", ctl.pass, 0);
        chk("rst_err", ctl.err_count, 0);
        chk("rst_ffv", ctl.first_fail_valid, 0);
        chk("rst_ffvec", ctl.first_fail_vec, 0);
        chk("rst_dutin", dut_in, 0);

        // 1: good chip, full run
        start_run();
        chk("t1_busy", ctl.busy, 1);
        wait_done("t1", n);
        chk("t1_cycles", n, 4096);
        chk("t1_pass", ctl.pass, 1);
        chk("t1_err", ctl.err_count, 0);
        chk("t1_ffv", ctl.first_fail_valid, 0);
        chk("t1_busy_end", ctl.busy, 0);
        chk("t1_dutin", dut_in, 10'h3FF);

        // 2: p1y stuck low
        mode = 1;
        start_run();
        wait_done("t2", n);
        chk("t2_cycles", n, 4096);
        chk("t2_err", ctl.err_count, 240);
        chk("t2_ffv", ctl.first_fail_valid, 1);
        chk("t2_ffvec", ctl.first_fail_vec, 7);
        chk("t2_pass", ctl.pass, 0);

        // 3: p2y stuck high
        mode = 2;
        start_run();
        chk("t3_done_clr", ctl.done, 0);
        chk("t3_err_clr", ctl.err_count, 0);
        chk("t3_ffv_clr", ctl.first_fail_valid, 0);
        wait_done("t3", n);
        chk("t3_err", ctl.err_count, 576);
        chk("t3_ffvec", ctl.first_fail_vec, 0);
        chk("t3_pass", ctl.pass, 0);

        // 4: abort at cycle 100 (vectors 0..23 sampled, vector 24 on the pins)
        start_run();
        repeat (99) tick();
        ctl.abort = 1'b1;
        tick();
        ctl.abort = 1'b0;
        chk("t4_busy", ctl.busy, 0);
        chk("t4_done", ctl.done, 0);
        chk("t4_err_hold", ctl.err_count, 24);
        chk("t4_ffv_hold", ctl.first_fail_valid, 1);
        chk("t4_ffvec_hold", ctl.first_fail_vec, 0);
        chk("t4_dutin_hold", dut_in, 24);
        repeat (5) tick();
        chk("t4_idle_busy", ctl.busy, 0);
        mode = 0;
        start_run();
        chk("t4_re_err", ctl.err_count, 0);
        chk("t4_re_ffv", ctl.first_fail_valid, 0);
        tick();
        chk("t4_re_vec0", dut_in, 0);
        wait_done("t4", n);
        chk("t4_cycles", n + 1, 4096);
        chk("t4_pass", ctl.pass, 1);

        // 5: start while busy is ignored; start in DONE restarts
        start_run();
        repeat (49) tick();
        ctl.start = 1'b1;
        tick();
        ctl.start = 1'b0;
        chk("t5_busy", ctl.busy, 1);
        wait_done("t5", n);
        chk("t5_cycles", n + 50, 4096);
        chk("t5_pass", ctl.pass, 1);
        start_run();
        chk("t5_done_drop", ctl.done, 0);
        chk("t5_rebusy", ctl.busy, 1);
        ctl.abort = 1'b1;
        tick();
        ctl.abort = 1'b0;
        chk("t5_abort", ctl.busy, 0);

        // 6: reset mid-SETTLE of vector 2 with errors already counted
        mode = 2;
        start_run();
        repeat (10) tick();
        chk("t6_pre_err", ctl.err_count, 2);
        chk("t6_pre_dutin", dut_in, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_busy", ctl.busy, 0);
        chk("t6_done", ctl.done, 0);
        chk("t6_err", ctl.err_count, 0);
        chk("t6_ffv", ctl.first_fail_valid, 0);
        chk("t6_dutin", dut_in, 0);
        mode = 0;
        start_run();
        wait_done("t6", n);
        chk("t6_cycles", n, 4096);
        chk("t6_pass", ctl.pass, 1);
        chk("t6_err_end", ctl.err_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
